// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready,
// branch/jump decisions returned from control, and the retired counter.
interface instr_fetch_unit_if #(
  parameter int CNT_W = 32
) ();
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       pc_out;
  logic [31:0]       pc_plus4;
  logic              branch;
  logic              zero;
  logic              jump;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, pc_out, pc_plus4,
    input  instr_ready,
    input  branch, zero, jump,
    output retired_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, pc_out, pc_plus4,
    output instr_ready,
    output branch, zero, jump,
    input  retired_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch stage: requests one word at a time from
// instruction memory, holds it for decode, then picks the next PC from the
// jump/branch/zero decisions returned on acceptance.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// HOLD  | instr/pc_out valid, waiting for instr_ready
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  // Low address bits forced to zero so pc stays word-aligned even if the
  // parameter is set carelessly.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       instr_q;
  logic [31:0]       pc_out_q;
  logic              req_q;
  logic              valid_q;
  logic [CNT_W-1:0]  retired_q;

  logic [31:0]       pc_plus4;
  logic [31:0]       branch_off;
  logic [31:0]       next_pc;

  assign pc_plus4   = pc_out_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next-PC select; only consumed on the accept edge. Jump beats branch.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jump)
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (bus.branch && bus.zero)
      next_pc = pc_plus4 + branch_off;
  end

  // Fetch/hold sequencing. req_q is held low for the first cycle out of
  // reset, and an ack is only honoured while a request is actually up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC_ALIGNED;
      instr_q   <= 32'h0;
      pc_out_q  <= RESET_PC_ALIGNED;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (req_q && bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            state    <= HOLD;
          end else begin
            req_q    <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            retired_q <= retired_q + CNT_W'(1);
            pc        <= next_pc;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            state     <= FETCH;
          end
        end
        default: begin
          state   <= FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc;
  assign bus.instr_valid   = valid_q;
  assign bus.instr         = instr_q;
  assign bus.pc_out        = pc_out_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.retired_count = retired_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential fetch stage; the upstream producer of the opcode stream decoded by control_unit.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction to the decode/control side over a valid/ready handshake.
- Consumes the resulting branch/zero/jump decisions to choose the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals pc.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr_valid  out  1  instr/pc_out hold a fetched instruction.
- instr_ready  in  1  decode side accepts the instruction this cycle.
- instr  out  32  fetched instruction; opcode = instr[31:26].
- pc_out  out  32  address of instr.
- pc_plus4  out  32  pc_out + 4.
- branch  in  1  from control_unit, qualified by acceptance.
- zero  in  1  ALU zero flag for the accepted instruction.
- jump  in  1  from control_unit, qualified by acceptance.
- retired_count  out  CNT_W  count of accepted instructions.

Behaviour:
- All outputs are registered or derived only from registered state; no combinational input-to-output paths.
- Reset (synchronous, takes effect at the clock edge):
  - pc = RESET_PC; state = FETCH.
  - imem_req = 0, instr_valid = 0, instr = 0, retired_count = 0.
  - imem_req rises on the first cycle after reset deasserts.
- FETCH state:
  - imem_req = 1; imem_addr = pc, stable until ack.
  - On an edge with imem_ack = 1: capture imem_rdata into instr; pc_out = pc; go to HOLD.
  - Minimum latency is 1 cycle from req to instr_valid when ack arrives in the same cycle as req.
- HOLD state:
  - instr_valid = 1; imem_req = 0; instr, pc_out and pc_plus4 stay stable while instr_ready = 0.
- Accept (HOLD and instr_ready = 1 at an edge):
  - retired_count increments, wrapping modulo 2^CNT_W.
  - Next pc, in priority order:
    - jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
    - else branch = 1 and zero = 1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
    - else: pc_plus4.
  - Go to FETCH; instr_valid = 0 next cycle. There are no back-to-back valid cycles, so throughput is at most 1 instruction per 2 cycles.
- branch, zero and jump are sampled only on the accept edge; they are ignored at all other times.
- jump and branch both high: jump wins.
- branch high with zero low: pc_plus4.
- imem_ack outside FETCH is ignored, and does not corrupt instr.
- pc wrap: pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000.
- pc[1:0] is always 00 by construction.
- reset asserted mid-FETCH or mid-HOLD:
  - Any pending request is abandoned and instr_valid drops at that edge.
  - An imem_ack in the reset cycle is ignored.
  - Fetch restarts at RESET_PC.
- instr_ready while not in HOLD is ignored.

Test Plan:
- Reset release, memory acks every cycle, instr_ready = 1 always:
  - imem_addr sequence 0x0, 0x4, 0x8, …
  - instr_valid pulses every 2nd cycle.
  - retired_count = 3 after three accepts.
- Memory ack delayed 3 cycles, instr_ready held low 4 cycles:
  - imem_addr stable throughout; instr and pc_out stable throughout.
  - Exactly one retired_count increment.
- beq at pc 0x10, instr = 32'h1000_0003, branch = 1, zero = 1:
  - next imem_addr = 0x20.
  - The same case with zero = 0 gives next imem_addr = 0x14.
- j at pc 0x4000_0008, instr = 32'h0800_0040, jump = 1, branch = 1, zero = 1:
  - next imem_addr = 0x4000_0100 (jump priority).
- Backward branch at pc 0x0, imm = 16'hFFFF, branch = zero = 1:
  - next imem_addr = 0x0.
- reset pulsed while in FETCH with imem_ack = 1 in the same cycle:
  - instr_valid stays 0 and retired_count = 0.
  - Next request is at RESET_PC.
  - Spurious imem_ack during HOLD leaves instr unchanged.
